lane_delay_calc: RTL and testbench

Upstream feeder for the phase timer in the smart traffic light controller. It counts vehicle-sensor pulses on four lanes over a fixed sampling window. At the end of each window it converts each lane's count into a clamped 4-bit green-phase delay. It drives the timer's `delay1`..`delay4` inputs and holds them stable for a full window.

---
 rtl/traffic_pkg.sv | 9 +
 rtl/sensor_sync_edge.sv | 28 ++
 rtl/lane_delay_calc.sv | 139 +++++++++++++
 tb/tb_lane_delay_calc.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light controller datapath.
package traffic_pkg;

  localparam int NUM_LANES = 4;
  localparam int DELAY_W   = 4;

  typedef logic [DELAY_W-1:0] delay_t;

endpackage

// File: rtl/sensor_sync_edge.sv
// Two-flop synchronizer for one raw lane sensor, followed by a rising-edge detector.
module sensor_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Synchronizer chain plus previous-value register; runs regardless of enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign rise = sync2_r & ~prev_r;

endmodule

// File: rtl/lane_delay_calc.sv
// Counts vehicle pulses per lane over a fixed window of enabled cycles and
// converts each count into a clamped green-phase delay for the phase timer.
module lane_delay_calc
  import traffic_pkg::*;
#(
  parameter int     WINDOW_CYCLES = 256,
  parameter int     CNT_W         = 8,
  parameter int     SHIFT         = 1,
  parameter delay_t MIN_DELAY     = 4'd2,
  parameter delay_t MAX_DELAY     = 4'd9,
  parameter delay_t DEFAULT_DELAY = 4'd3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_LANES-1:0] sensor,
  output logic [DELAY_W-1:0]   delay1,
  output logic [DELAY_W-1:0]   delay2,
  output logic [DELAY_W-1:0]   delay3,
  output logic [DELAY_W-1:0]   delay4,
  output logic                 update,
  output logic [NUM_LANES-1:0] sat
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES);
  // Extra headroom so MIN_DELAY + shifted count can never wrap before the clamp.
  localparam int RAW_W = (CNT_W + 1 > DELAY_W + 1) ? CNT_W + 1 : DELAY_W + 1;
  localparam logic [WIN_W-1:0] LAST_WIN = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [WIN_W-1:0]     win_cnt_r;
  logic [NUM_LANES-1:0] edge_s;
  logic [NUM_LANES-1:0] bump_s;
  logic [CNT_W-1:0]     cnt_r     [NUM_LANES];
  logic [CNT_W-1:0]     cnt_nxt_s [NUM_LANES];
  logic [NUM_LANES-1:0] flag_r;
  logic [NUM_LANES-1:0] flag_nxt_s;
  logic [RAW_W-1:0]     raw_s     [NUM_LANES];
  delay_t               dly_nxt_s [NUM_LANES];
  delay_t               dly_r     [NUM_LANES];
  logic                 terminal_s;
  logic                 update_r;
  logic [NUM_LANES-1:0] sat_r;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    sensor_sync_edge u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (sensor[g]),
      .rise  (edge_s[g])
    );
  end

  // Next lane counts (including a terminal-cycle edge) and their converted delays.
  always_comb begin
    terminal_s = enable && (win_cnt_r == LAST_WIN);
    bump_s     = {NUM_LANES{1'b0}};
    flag_nxt_s = flag_r;
    for (int i = 0; i < NUM_LANES; i++) begin
      bump_s[i] = enable && edge_s[i] && (cnt_r[i] != CNT_MAX);
      if (bump_s[i]) begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
      flag_nxt_s[i] = flag_r[i] | (cnt_nxt_s[i] == CNT_MAX);
      raw_s[i]      = RAW_W'(MIN_DELAY) + RAW_W'(cnt_nxt_s[i] >> SHIFT);
      if (raw_s[i] > RAW_W'(MAX_DELAY)) begin
        dly_nxt_s[i] = MAX_DELAY;
      end else begin
        dly_nxt_s[i] = raw_s[i][DELAY_W-1:0];
      end
    end
  end

  // Window counter: advances only on enabled cycles and wraps after the terminal cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt_r <= {WIN_W{1'b0}};
    end else if (terminal_s) begin
      win_cnt_r <= {WIN_W{1'b0}};
    end else if (enable) begin
      win_cnt_r <= win_cnt_r + WIN_W'(1);
    end else begin
      win_cnt_r <= win_cnt_r;
    end
  end

  // Saturating lane counters and flags; the terminal cycle hands off and clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_r <= {NUM_LANES{1'b0}};
      for (int i = 0; i < NUM_LANES; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else if (terminal_s) begin
      flag_r <= {NUM_LANES{1'b0}};
      for (int i = 0; i < NUM_LANES; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      flag_r <= flag_nxt_s;
      for (int i = 0; i < NUM_LANES; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  // Output registers hold the last completed window's results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      update_r <= 1'b0;
      sat_r    <= {NUM_LANES{1'b0}};
      for (int i = 0; i < NUM_LANES; i++) begin
        dly_r[i] <= DEFAULT_DELAY;
      end
    end else if (terminal_s) begin
      update_r <= 1'b1;
      sat_r    <= flag_nxt_s;
      for (int i = 0; i < NUM_LANES; i++) begin
        dly_r[i] <= dly_nxt_s[i];
      end
    end else begin
      update_r <= 1'b0;
      sat_r    <= sat_r;
      for (int i = 0; i < NUM_LANES; i++) begin
        dly_r[i] <= dly_r[i];
      end
    end
  end

  assign delay1 = dly_r[0];
  assign delay2 = dly_r[1];
  assign delay3 = dly_r[2];
  assign delay4 = dly_r[3];
  assign update = update_r;
  assign sat    = sat_r;

endmodule

// File: tb/tb_lane_delay_calc.sv
// Randomized and directed bench for lane_delay_calc against a window-level count model.
module tb_lane_delay_calc;

  localparam int WIN   = 16;
  localparam int CNTW  = 4;
  localparam int SHF   = 1;
  localparam int MIND  = 2;
  localparam int MAXD  = 9;
  localparam int DEFD  = 3;
  localparam int CMAX  = (1 << CNTW) - 1;
  localparam int WIN2  = 48;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] sensor = 4'd0;
  logic [3:0] delay1, delay2, delay3, delay4;
  logic       update;
  logic [3:0] sat;

  logic       enable2 = 1'b0;
  logic [3:0] sensor2 = 4'd0;
  logic [3:0] d2_1, d2_2, d2_3, d2_4;
  logic       update2;
  logic [3:0] sat2;

  int checks = 0;
  int errors = 0;

  // Model state: unbounded per-lane vehicle counts, clamped only at window close.
  int         cnt_m [4];
  int         dly_m [4];
  int         wc_m;
  logic       upd_m;
  logic [3:0] sat_m;
  logic [3:0] h0, h1, h2;

  always #5 clk = ~clk;

  lane_delay_calc #(
    .WINDOW_CYCLES(WIN), .CNT_W(CNTW), .SHIFT(SHF),
    .MIN_DELAY(4'd2), .MAX_DELAY(4'd9), .DEFAULT_DELAY(4'd3)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sensor(sensor),
    .delay1(delay1), .delay2(delay2), .delay3(delay3), .delay4(delay4),
    .update(update), .sat(sat)
  );

  lane_delay_calc #(
    .WINDOW_CYCLES(WIN2), .CNT_W(CNTW), .SHIFT(SHF),
    .MIN_DELAY(4'd2), .MAX_DELAY(4'd9), .DEFAULT_DELAY(4'd3)
  ) dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .sensor(sensor2),
    .delay1(d2_1), .delay2(d2_2), .delay3(d2_3), .delay4(d2_4),
    .update(update2), .sat(sat2)
  );

  // A raw rise seen at one edge is a vehicle two edges later; counts close every WIN enabled cycles.
  always @(posedge clk or negedge reset) begin : model
    if (!reset) begin
      for (int l = 0; l < 4; l++) begin
        cnt_m[l] <= 0;
        dly_m[l] <= DEFD;
      end
      wc_m  <= 0;
      upd_m <= 1'b0;
      sat_m <= 4'd0;
      h0 <= 4'd0; h1 <= 4'd0; h2 <= 4'd0;
    end else begin
      for (int l = 0; l < 4; l++) begin
        automatic int c = cnt_m[l] + ((enable && h1[l] && !h2[l]) ? 1 : 0);
        automatic int d = MIND + (((c > CMAX) ? CMAX : c) >> SHF);
        if (enable && wc_m == WIN - 1) begin
          dly_m[l] <= (d > MAXD) ? MAXD : d;
          sat_m[l] <= (c >= CMAX);
          cnt_m[l] <= 0;
        end else if (enable) begin
          cnt_m[l] <= c;
        end
      end
      upd_m <= enable && (wc_m == WIN - 1);
      if (enable) wc_m <= (wc_m == WIN - 1) ? 0 : wc_m + 1;
      h2 <= h1; h1 <= h0; h0 <= sensor;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("delay1", int'(delay1), dly_m[0]);
    chk("delay2", int'(delay2), dly_m[1]);
    chk("delay3", int'(delay3), dly_m[2]);
    chk("delay4", int'(delay4), dly_m[3]);
    chk("update", int'(update), int'(upd_m));
    chk("sat",    int'(sat),    int'(sat_m));
  endtask

  // One clock period: drive at negedge+1, cross one posedge, compare at the next negedge.
  task automatic drive_slot(input logic en, input logic [3:0] s);
    enable = en;
    sensor = s;
    @(negedge clk);
    compare_model();
    #1;
  endtask

  task automatic run_window(input logic [15:0] p1, input logic [15:0] p2,
                            input logic [15:0] p3, input logic [15:0] p4);
    for (int i = 0; i < WIN; i++) drive_slot(1'b1, {p4[i], p3[i], p2[i], p1[i]});
  endtask

  initial begin
    logic [31:0] r;
    repeat (3) @(negedge clk);
    chk("rst_delay1", int'(delay1), 3);
    chk("rst_delay4", int'(delay4), 3);
    chk("rst_update", int'(update), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_d2_1", int'(d2_1), 3);
    #1 reset = 1'b1;

    for (int i = 0; i < 40; i++) drive_slot(1'b0, 4'd0);
    chk("idle_delay2", int'(delay2), 3);
    chk("idle_update", int'(update), 0);

    // Basic window: 4, 0, 7, 1 pulses.
    run_window(16'h0055, 16'h0000, 16'h1555, 16'h0001);
    chk("basic_d1", int'(delay1), 4);
    chk("basic_d2", int'(delay2), 2);
    chk("basic_d3", int'(delay3), 5);
    chk("basic_d4", int'(delay4), 2);
    chk("basic_update", int'(update), 1);
    drive_slot(1'b0, 4'd0);
    chk("basic_update_once", int'(update), 0);

    // Terminal-cycle edge on lane3 belongs to the closing window only.
    run_window(16'h0000, 16'h0000, 16'h2800, 16'h0000);
    chk("term_d3", int'(delay3), 3);
    run_window(16'h0000, 16'h0000, 16'h0002, 16'h0000);
    chk("term_next_d3", int'(delay3), 2);

    // Enable gap with lane2 activity while disabled and held high across the enable rise.
    for (int i = 0; i < 8; i++) drive_slot(1'b1, {2'b00, (i == 0 || i == 2), 1'b0});
    for (int d = 0; d < 10; d++) drive_slot(1'b0, {2'b00, (d == 1 || d == 3 || d >= 5), 1'b0});
    for (int i = 8; i < 15; i++) drive_slot(1'b1, {2'b00, (i < 10), 1'b0});
    chk("gap_no_early_update", int'(update), 0);
    drive_slot(1'b1, 4'd0);
    chk("gap_update", int'(update), 1);
    chk("gap_d2", int'(delay2), 3);

    // Asynchronous reset partway through a window with three counted pulses.
    for (int i = 0; i < 8; i++) drive_slot(1'b1, {3'b000, (i == 0 || i == 2 || i == 4)});
    #5 reset = 1'b0;
    #1;
    chk("arst_d1", int'(delay1), 3);
    chk("arst_d2", int'(delay2), 3);
    chk("arst_update", int'(update), 0);
    #2 reset = 1'b1;
    #2;
    for (int i = 0; i < 15; i++) drive_slot(1'b1, 4'd0);
    chk("arst_no_early_update", int'(update), 0);
    drive_slot(1'b1, 4'd0);
    chk("arst_update_16", int'(update), 1);

    // Random traffic with random enable gaps.
    for (int i = 0; i < 800; i++) begin
      r = $urandom();
      drive_slot(r[7:4] != 4'd0, r[3:0]);
    end

    // Wider window: 20 pulses on lane1 saturate the counter.
    for (int i = 0; i < WIN2; i++) begin
      enable2 = 1'b1;
      sensor2 = {3'b000, (i < 40) && (i % 2 == 0)};
      drive_slot(1'b0, 4'd0);
    end
    chk("clamp_d1", int'(d2_1), 9);
    chk("clamp_sat", int'(sat2), 1);
    chk("clamp_update", int'(update2), 1);
    chk("clamp_d2", int'(d2_2), 2);
    sensor2 = 4'd0;
    for (int i = 0; i < WIN2; i++) drive_slot(1'b0, 4'd0);
    chk("clamp_next_d1", int'(d2_1), 2);
    chk("clamp_next_sat", int'(sat2), 0);
    chk("clamp_next_update", int'(update2), 1);
    enable2 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
